// File: rtl/halut_decoder.sv
// halut_decoder: looks up (codebook, prototype) partial products in a writable LUT
// and accumulates C of them into one output element, with a two-stage pipeline.
module halut_decoder #(
  parameter int K             = 16,
  parameter int C             = 32,
  parameter int DataTypeWidth = 8,
  parameter int TreeDepth     = $clog2(K),
  parameter int CAddrWidth    = $clog2(C),
  parameter int LutAddrWidth  = CAddrWidth + TreeDepth,
  parameter int AccWidth      = DataTypeWidth + CAddrWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [TreeDepth-1:0]     k_addr_i,
  input  logic                     valid_i,
  input  logic [LutAddrWidth-1:0]  waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  input  logic                     clear_i,
  output logic [AccWidth-1:0]      result_o,
  output logic                     valid_o,
  output logic                     busy_o
);
  logic [DataTypeWidth-1:0] lut_mem [C*K];
  logic [DataTypeWidth-1:0] lut_q;
  logic [CAddrWidth-1:0]    cnt;
  logic                     v1_q, first1_q, last1_q;
  logic [AccWidth-1:0]      acc, sum;
  // LUT is not reset; a same-cycle read sees the old entry
  always_ff @(posedge clk_i) if (we_i) lut_mem[waddr_i] <= wdata_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      lut_q    <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (clear_i) begin
      cnt  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        lut_q    <= lut_mem[{c_addr_i, k_addr_i}];
        first1_q <= cnt == '0;
        last1_q  <= cnt == CAddrWidth'(C - 1);
        cnt      <= cnt + CAddrWidth'(1);
      end
    end
  end
  // first token of an element ignores the stale acc, so elements need no bubble
  assign sum = (first1_q ? '0 : acc) + AccWidth'($signed(lut_q));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc      <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else if (clear_i) begin
      acc     <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= v1_q && last1_q;
      if (v1_q) acc <= sum;
      if (v1_q && last1_q) result_o <= sum;
    end
  end
  assign busy_o = (cnt != '0) | v1_q;
endmodule

// File: doc/halut_decoder.md
# halut_decoder

Downstream stage of the halut encoder units. Consumes the stream of (codebook, prototype) index pairs produced by the encoders, looks up the matching pre-computed partial product in a writable lookup-table memory, and accumulates one entry per codebook. After C accepted indices it emits one accumulated output element and restarts.

## Interface

Parameters:

- K, 16: prototypes per codebook; power of two.
- C, 32: codebooks per output element; power of two.
- DataTypeWidth, 8: width of one LUT entry, signed two's complement.
- TreeDepth, $clog2(K): prototype index width.
- CAddrWidth, $clog2(C): codebook index width.
- LutAddrWidth, CAddrWidth + TreeDepth: LUT memory address width; depth C*K.
- AccWidth, DataTypeWidth + CAddrWidth: accumulator and result width, signed. This width cannot overflow.

Ports:

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- c_addr_i  in  CAddrWidth  codebook index from the encoder.
- k_addr_i  in  TreeDepth  prototype index from the encoder.
- valid_i  in  1  index pair valid. There is no backpressure: every valid cycle must be accepted.
- waddr_i  in  LutAddrWidth  LUT write address, equal to {c, k}.
- wdata_i  in  DataTypeWidth  LUT write data.
- we_i  in  1  LUT write enable.
- clear_i  in  1  synchronous flush of the accumulation state.
- result_o  out  AccWidth  accumulated output element.
- valid_o  out  1  one-cycle pulse marking result_o as new.
- busy_o  out  1  high while a partial accumulation is in flight.

## Operation

LUT memory:

- C*K entries of DataTypeWidth.
- Write on the rising edge when we_i is set.
- Read is combinational at address {c_addr_i, k_addr_i}.
- Same-cycle write and read to the same address returns the OLD data.

Stage 1, the cycle in which valid_i is set:

- lut_q <= LUT[{c_addr_i, k_addr_i}].
- v1_q <= 1.
- first1_q <= (cnt == 0).
- last1_q <= (cnt == C-1).
- cnt increments and wraps from C-1 to 0.
- In cycles where valid_i is low: v1_q <= 0 and cnt holds.

Counting and index order:

- cnt counts accepted tokens only; c_addr_i is not checked against cnt.
- The C tokens of one output may arrive in any codebook order and with gaps of any length.

Stage 2, when v1_q is set:

- acc <= (first1_q ? 0 : acc) + sign_extend(lut_q), with AccWidth two's complement arithmetic.
- If last1_q is set: result_o <= the same sum and valid_o <= 1. Otherwise valid_o <= 0.
- When v1_q is low: valid_o <= 0 and acc holds.

result_o holds its value until the next completed element.

busy_o = (cnt != 0) | v1_q.

clear_i:

- Sets cnt, v1_q and acc to 0 and forces valid_o to 0 on the next edge.
- result_o keeps its last value.
- A valid_i in the same cycle as clear_i is dropped.
- LUT contents are unaffected.

## Timing

Reset values:

- result_o = 0, valid_o = 0, busy_o = 0.
- cnt = 0, acc = 0, lut_q = 0, v1_q = 0.
- LUT contents are undefined after reset and must be written before use.

Latency and throughput:

- The C-th valid_i accepted at edge t produces valid_o high during cycle t+2, i.e. two cycles after it is sampled.
- Throughput is one token per cycle.
- Back-to-back elements need no gap: the token after the last one starts a new sum without a bubble, because first1_q ignores the old acc.

Boundary conditions:

- cnt wrap: C-1 to 0, together with the last1_q flag.
- A LUT write in the same cycle as a read of that address: stage 1 captures the old data; the new data is visible from the next cycle.
- Asynchronous reset mid-element discards the partial sum; the next valid_i is treated as the first token.
- clear_i while the last token sits in stage 1: no valid_o is produced.

## Test plan

- Reset: assert rst_ni low mid-stream -> result_o=0, valid_o=0, busy_o=0 immediately; the next C tokens form a complete element.
- Basic sum: LUT[{c,k}] = c+1 for all k; feed C=32 tokens c=0..31 with k=c%16 on consecutive cycles -> a single valid_o pulse 2 cycles after the last token, result_o=528.
- Signed and full-range values: all LUT entries = -128 (0x80), 32 tokens -> result_o = -4096 (13-bit 0x1000), no overflow.
- Back-to-back with gaps: two elements, the second with random idle cycles and shuffled c order, LUT = c -> two pulses, each result_o=496; busy_o=0 only between elements.
- clear_i after 10 tokens, then 32 tokens -> exactly one valid_o, with a sum over the last 32 tokens only. clear_i coincident with valid_i -> that token is not counted.
- Write/read collision: write LUT[{3,5}]=7 (old value 1) while valid_i reads {3,5} in the same cycle -> that token contributes 1; a later read contributes 7.
